// File: rtl/lc3_dp_pkg.sv
// Shared types for the parametrised LC-3 datapath: mux/ALU selects,
// condition-code reset value and the MDR read FSM state.
package lc3_dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_PASS = 2'd3
  } aluk_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_BUS  = 2'd1,
    PC_ADDR = 2'd2,
    PC_HOLD = 2'd3
  } pcmux_e;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'd0,
    A2_OFF6  = 2'd1,
    A2_OFF9  = 2'd2,
    A2_OFF11 = 2'd3
  } addr2_e;

  typedef enum logic [1:0] {
    DR_IR119 = 2'd0,
    DR_R7    = 2'd1,
    DR_R6A   = 2'd2,
    DR_R6B   = 2'd3
  } drmux_e;

  typedef enum logic [1:0] {
    SR1_IR119 = 2'd0,
    SR1_IR86  = 2'd1,
    SR1_R6A   = 2'd2,
    SR1_R6B   = 2'd3
  } sr1mux_e;

  // CC is {N, Z, P}
  localparam logic [2:0] CC_RESET = 3'b010;

  typedef enum logic {
    MDR_IDLE = 1'b0,
    MDR_WAIT = 1'b1
  } mdr_state_e;

endpackage

// File: rtl/lc3_regfile.sv
// 8 x WIDTH register file: two async read ports, one sync write port.
// Ports: clk_i, rst_i (sync, high), we_i/waddr_i/wdata_i, raddr{1,2}_i, rdata{1,2}_o.
module lc3_regfile #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [2:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [2:0]       raddr1_i,
  output logic [WIDTH-1:0] rdata1_o,
  input  logic [2:0]       raddr2_i,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] rf_q [8];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];

endmodule

// File: rtl/lc3_datapath.sv
// Parametrised LC-3 datapath: PC/IR/MAR/MDR, regfile, ALU, address adder,
// shared bus, CC/BEN, MDR wait-state FSM and sticky bus-contention flag.
// Ports: ISDU control strobes/selects in; MDR_in/mem_ready from memory;
// MDR_out/MAR_out/IR_out/PC_out, BEN, mdr_wait, bus_err out.
module lc3_datapath_param
  import lc3_dp_pkg::*;
#(
  parameter int          WIDTH    = 16,
  parameter logic [63:0] PC_RESET = 64'h3000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             GateMARMUX,
  input  logic             GatePC,
  input  logic             GateALU,
  input  logic             GateMDR,
  input  logic             LD_REG,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_IR,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_PC,
  input  logic             ADDR1MUX,
  input  logic             SR2MUX,
  input  logic             MIO_EN,
  input  logic [1:0]       PCMUX,
  input  logic [1:0]       DRMUX,
  input  logic [1:0]       SR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic [WIDTH-1:0] MDR_in,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] MDR_out,
  output logic [WIDTH-1:0] MAR_out,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-1:0] PC_out,
  output logic             BEN,
  output logic             mdr_wait,
  output logic             bus_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, mar_q, mdr_q;
  logic [2:0]       cc_q, cc_d;
  logic             ben_q, err_q;
  mdr_state_e       st_q;

  logic [WIDTH-1:0] bus, alu, addr1, addr2, addr_sum, sr2_op;
  logic [WIDTH-1:0] sr1_data, sr2_data;
  logic [2:0]       sr1_a, dr_a;
  logic [3:0]       gates;
  logic             multi;

  logic [WIDTH-1:0] off6, off9, off11, imm5;
  assign off6  = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign off9  = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
  assign off11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
  assign imm5  = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};

  always_comb begin
    sr1_a = ir_q[11:9];
    unique case (sr1mux_e'(SR1MUX))
      SR1_IR119: sr1_a = ir_q[11:9];
      SR1_IR86:  sr1_a = ir_q[8:6];
      SR1_R6A:   sr1_a = 3'd6;
      SR1_R6B:   sr1_a = 3'd6;
    endcase
  end

  always_comb begin
    dr_a = ir_q[11:9];
    unique case (drmux_e'(DRMUX))
      DR_IR119: dr_a = ir_q[11:9];
      DR_R7:    dr_a = 3'd7;
      DR_R6A:   dr_a = 3'd6;
      DR_R6B:   dr_a = 3'd6;
    endcase
  end

  lc3_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (LD_REG),
    .waddr_i (dr_a),
    .wdata_i (bus),
    .raddr1_i(sr1_a),
    .rdata1_o(sr1_data),
    .raddr2_i(ir_q[2:0]),
    .rdata2_o(sr2_data)
  );

  assign addr1 = ADDR1MUX ? sr1_data : pc_q;

  always_comb begin
    addr2 = '0;
    unique case (addr2_e'(ADDR2MUX))
      A2_ZERO:  addr2 = '0;
      A2_OFF6:  addr2 = off6;
      A2_OFF9:  addr2 = off9;
      A2_OFF11: addr2 = off11;
    endcase
  end

  assign addr_sum = addr1 + addr2;
  assign sr2_op   = SR2MUX ? imm5 : sr2_data;

  always_comb begin
    alu = '0;
    unique case (aluk_e'(ALUK))
      ALU_ADD:  alu = sr1_data + sr2_op;
      ALU_AND:  alu = sr1_data & sr2_op;
      ALU_NOT:  alu = ~sr1_data;
      ALU_PASS: alu = sr1_data;
    endcase
  end

  // Contention drives zero rather than an arbitrary winner.
  assign gates = {GateMARMUX, GatePC, GateALU, GateMDR};
  assign multi = (gates & (gates - 4'd1)) != 4'd0;

  always_comb begin
    bus = '0;
    if (!multi) begin
      unique case (1'b1)
        GateMARMUX: bus = addr_sum;
        GatePC:     bus = pc_q;
        GateALU:    bus = alu;
        GateMDR:    bus = mdr_q;
        default:    bus = '0;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pcmux_e'(PCMUX))
      PC_INC:  pc_d = pc_q + 1'b1;
      PC_BUS:  pc_d = bus;
      PC_ADDR: pc_d = addr_sum;
      PC_HOLD: pc_d = pc_q;
    endcase
  end

  always_comb begin
    cc_d[2] = bus[WIDTH-1];
    cc_d[1] = (bus == '0);
    cc_d[0] = !bus[WIDTH-1] && (bus != '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= PC_RESET[WIDTH-1:0];
      ir_q  <= '0;
      mar_q <= '0;
      cc_q  <= CC_RESET;
      ben_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (LD_PC)  pc_q  <= pc_d;
      if (LD_IR)  ir_q  <= bus;
      if (LD_MAR) mar_q <= bus;
      if (LD_CC)  cc_q  <= cc_d;
      if (LD_BEN) ben_q <= (ir_q[11] & cc_q[2]) |
                           (ir_q[10] & cc_q[1]) |
                           (ir_q[9]  & cc_q[0]);
      if (multi)  err_q <= 1'b1;
    end
  end

  // MDR load path; a memory read without mem_ready parks in WAIT
  // and ignores further LD_MDR until the data arrives.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q  <= MDR_IDLE;
      mdr_q <= '0;
    end else begin
      unique case (st_q)
        MDR_IDLE: begin
          if (LD_MDR) begin
            if (!MIO_EN)        mdr_q <= bus;
            else if (mem_ready) mdr_q <= MDR_in;
            else                st_q  <= MDR_WAIT;
          end
        end
        MDR_WAIT: begin
          if (mem_ready) begin
            mdr_q <= MDR_in;
            st_q  <= MDR_IDLE;
          end
        end
      endcase
    end
  end

  assign MDR_out  = mdr_q;
  assign MAR_out  = mar_q;
  assign IR_out   = ir_q;
  assign PC_out   = pc_q;
  assign BEN      = ben_q;
  assign mdr_wait = (st_q == MDR_WAIT);
  assign bus_err  = err_q;

endmodule

// File: tb/tb_lc3_datapath_param.sv
// Bench for lc3_datapath_param: directed vectors, queued expectations,
// monitor compares on the falling edge; 16-bit and 32-bit instances.
module tb_lc3_datapath_param;

  typedef enum int {
    S_PC, S_IR, S_MAR, S_MDR, S_BEN, S_WAIT, S_ERR,
    S_PC32, S_IR32, S_MAR32
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;
  int   n_run = 0;
  int   n_fail = 0;

  logic Clk = 1'b0;
  logic Reset;
  logic GateMARMUX, GatePC, GateALU, GateMDR;
  logic LD_REG, LD_BEN, LD_CC, LD_IR, LD_MAR, LD_MDR, LD_PC;
  logic ADDR1MUX, SR2MUX, MIO_EN;
  logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
  logic [15:0] MDR_in;
  logic [31:0] MDR_in32;
  logic mem_ready;

  logic [15:0] mdr_o, mar_o, ir_o, pc_o;
  logic ben_o, wait_o, err_o;
  logic [31:0] mdr32, mar32, ir32, pc32;
  logic ben32, wait32, err32;

  assign MDR_in32 = {16'h0, MDR_in};

  always #5 Clk = ~Clk;
  always @(posedge Clk) cnt <= cnt + 1;

  lc3_datapath_param #(.WIDTH(16), .PC_RESET(64'h3000)) dut16 (
    .Clk(Clk), .Reset(Reset),
    .GateMARMUX(GateMARMUX), .GatePC(GatePC),
    .GateALU(GateALU), .GateMDR(GateMDR),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_PC(LD_PC), .ADDR1MUX(ADDR1MUX), .SR2MUX(SR2MUX),
    .MIO_EN(MIO_EN), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .MDR_in(MDR_in), .mem_ready(mem_ready),
    .MDR_out(mdr_o), .MAR_out(mar_o), .IR_out(ir_o),
    .PC_out(pc_o), .BEN(ben_o), .mdr_wait(wait_o),
    .bus_err(err_o)
  );

  lc3_datapath_param #(.WIDTH(32), .PC_RESET(64'hFFFF_FFFF)) dut32 (
    .Clk(Clk), .Reset(Reset),
    .GateMARMUX(GateMARMUX), .GatePC(GatePC),
    .GateALU(GateALU), .GateMDR(GateMDR),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_PC(LD_PC), .ADDR1MUX(ADDR1MUX), .SR2MUX(SR2MUX),
    .MIO_EN(MIO_EN), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .MDR_in(MDR_in32), .mem_ready(mem_ready),
    .MDR_out(mdr32), .MAR_out(mar32), .IR_out(ir32),
    .PC_out(pc32), .BEN(ben32), .mdr_wait(wait32),
    .bus_err(err32)
  );

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_PC:    return {16'h0, pc_o};
      S_IR:    return {16'h0, ir_o};
      S_MAR:   return {16'h0, mar_o};
      S_MDR:   return {16'h0, mdr_o};
      S_BEN:   return {31'h0, ben_o};
      S_WAIT:  return {31'h0, wait_o};
      S_ERR:   return {31'h0, err_o};
      S_PC32:  return pc32;
      S_IR32:  return ir32;
      S_MAR32: return mar32;
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  // Monitor: the DUT presents registered state once per cycle; pop and
  // compare every expectation due at this cycle.
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc <= cnt) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      n_run++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d)",
                 e.name, a, e.val, cnt);
      end
    end
  end

  task automatic idle();
    GateMARMUX = 0; GatePC = 0; GateALU = 0; GateMDR = 0;
    LD_REG = 0; LD_BEN = 0; LD_CC = 0; LD_IR = 0;
    LD_MAR = 0; LD_MDR = 0; LD_PC = 0;
    ADDR1MUX = 0; SR2MUX = 0; MIO_EN = 0;
    PCMUX = 0; DRMUX = 0; SR1MUX = 0; ADDR2MUX = 0; ALUK = 0;
    mem_ready = 0; Reset = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    idle();
  endtask

  // Expectation for state after the upcoming edge.
  task automatic chk(sig_e s, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cnt + 1; e.sig = s; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  // Expectation for the state presented right now.
  task automatic chk_now(sig_e s, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cnt; e.sig = s; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic load_ir(logic [15:0] v);
    LD_MDR = 1; MIO_EN = 1; mem_ready = 1; MDR_in = v;
    chk(S_MDR, {16'h0, v}, "mdr_imm");
    chk(S_WAIT, 0, "mdr_imm_nowait");
    tick();
    GateMDR = 1; LD_IR = 1;
    chk(S_IR, {16'h0, v}, "ir_load");
    chk(S_IR32, {16'h0, v}, "ir32_load");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    MDR_in = 16'h0;
    Reset = 1;
    tick();
    chk_now(S_PC, 32'h3000, "rst_pc");
    chk_now(S_IR, 0, "rst_ir");
    chk_now(S_MAR, 0, "rst_mar");
    chk_now(S_MDR, 0, "rst_mdr");
    chk_now(S_BEN, 0, "rst_ben");
    chk_now(S_WAIT, 0, "rst_wait");
    chk_now(S_ERR, 0, "rst_err");
    chk_now(S_PC32, 32'hFFFF_FFFF, "rst_pc32");

    GatePC = 1; LD_MAR = 1;
    chk(S_MAR, 32'h3000, "mar_from_pc");
    tick();

    GatePC = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 0;
    chk(S_PC, 32'h3001, "pc_inc");
    chk(S_MAR, 32'h3000, "bus_old_pc");
    tick();

    // CC still at reset (Z): IR[10] selects it
    load_ir(16'h0400);
    LD_BEN = 1;
    chk(S_BEN, 1, "ben_cc_reset_z");
    tick();

    // R1 <- 7FFF via MDR
    load_ir(16'h0200);
    LD_MDR = 1; MIO_EN = 1; mem_ready = 1; MDR_in = 16'h7FFF;
    chk(S_MDR, 32'h7FFF, "mdr_7fff");
    tick();
    GateMDR = 1; LD_REG = 1; DRMUX = 0;
    tick();
    GateALU = 1; ALUK = 3; SR1MUX = 0; LD_MAR = 1;
    chk(S_MAR, 32'h7FFF, "r1_pass");
    tick();

    // ADD R2, R1, #1
    load_ir(16'h1461);
    SR1MUX = 1; SR2MUX = 1; ALUK = 0; GateALU = 1;
    LD_REG = 1; DRMUX = 0; LD_CC = 1; LD_MAR = 1;
    chk(S_MAR, 32'h8000, "add_imm_wrap");
    tick();
    GateALU = 1; ALUK = 2; SR1MUX = 0; LD_MAR = 1;
    chk(S_MAR, 32'h7FFF, "not_r2");
    tick();
    LD_BEN = 1;
    chk(S_BEN, 0, "ben_z_vs_n");
    tick();
    load_ir(16'h0800);
    LD_BEN = 1;
    chk(S_BEN, 1, "ben_n");
    tick();

    // Wait-state read
    LD_MDR = 1; MIO_EN = 1; mem_ready = 0;
    chk(S_WAIT, 1, "wait_c0");
    chk(S_MDR, 32'h0800, "hold_c0");
    tick();
    for (int i = 1; i < 3; i++) begin
      LD_MDR = 1; MIO_EN = 0; GatePC = 1;
      chk(S_WAIT, 1, "wait_cn");
      chk(S_MDR, 32'h0800, "ld_mdr_ignored");
      tick();
    end
    mem_ready = 1; MDR_in = 16'hBEEF;
    chk(S_WAIT, 0, "wait_done");
    chk(S_MDR, 32'hBEEF, "mdr_beef");
    tick();
    MDR_in = 16'h1111;
    chk(S_MDR, 32'hBEEF, "mdr_hold");
    tick();

    // Reset while waiting drops the read
    LD_MDR = 1; MIO_EN = 1; mem_ready = 0;
    chk(S_WAIT, 1, "wait_pre_rst");
    tick();
    Reset = 1;
    chk(S_MDR, 0, "rst_wait_mdr");
    chk(S_WAIT, 0, "rst_wait_state");
    chk(S_PC, 32'h3000, "rst_wait_pc");
    tick();
    mem_ready = 1; MDR_in = 16'h1234;
    chk(S_MDR, 0, "late_ready_ignored");
    chk(S_WAIT, 0, "late_ready_idle");
    tick();

    // Bus contention
    GatePC = 1; LD_MAR = 1;
    chk(S_MAR, 32'h3000, "mar_pre_err");
    tick();
    GatePC = 1; GateALU = 1; LD_MAR = 1;
    chk(S_MAR, 0, "contention_bus0");
    chk(S_ERR, 1, "err_set");
    tick();
    chk(S_ERR, 1, "err_sticky1");
    tick();
    chk(S_ERR, 1, "err_sticky2");
    tick();
    Reset = 1;
    chk(S_ERR, 0, "err_cleared");
    chk(S_PC32, 32'hFFFF_FFFF, "rst_pc32_b");
    tick();

    // 32-bit: PC wrap and 11-bit offset
    LD_PC = 1; PCMUX = 0;
    chk(S_PC32, 0, "pc32_wrap");
    chk(S_PC, 32'h3001, "pc16_inc");
    tick();
    load_ir(16'h0400);
    GateMARMUX = 1; ADDR1MUX = 0; ADDR2MUX = 3; LD_MAR = 1;
    chk(S_MAR32, 32'hFFFF_FC00, "off11_sext32");
    chk(S_MAR, 32'h2C01, "off11_sext16");
    tick();
    LD_PC = 1; PCMUX = 2; ADDR2MUX = 3;
    chk(S_PC32, 32'hFFFF_FC00, "pc32_addr");
    chk(S_PC, 32'h2C01, "pc16_addr");
    tick();

    tick();
    tick();
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_datapath_param.md
# lc3_datapath_param

Parametrised successor to the current LC-3 datapath: PC, IR, MAR, MDR, 8-entry register file, ALU, address adder and shared bus, generalised to a configurable data width and reset PC. It adds the condition-code and BEN registers, a wait-state handshake on memory reads into MDR, and a sticky bus-contention flag. It sits between the ISDU control FSM and the memory/SRAM interface.

## Interface
- WIDTH, 16, datapath/bus width; must be >= 16 (instruction fields always decoded from IR[15:0]).
- PC_RESET, 'h3000, PC value after reset; truncated to WIDTH.
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- GateMARMUX, GatePC, GateALU, GateMDR  in  1 each  bus drivers; at most one asserted.
- LD_REG, LD_BEN, LD_CC, LD_IR, LD_MAR, LD_MDR, LD_PC  in  1 each  register load enables.
- ADDR1MUX, SR2MUX, MIO_EN  in  1 each  mux selects; MIO_EN=1 selects MDR_in into MDR.
- PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK  in  2 each  mux/ALU selects.
- MDR_in  in  WIDTH  memory read data.
- mem_ready  in  1  MDR_in valid this cycle.
- MDR_out, MAR_out, IR_out, PC_out  out  WIDTH  register contents.
- BEN  out  1  registered branch enable.
- mdr_wait  out  1  memory read into MDR outstanding.
- bus_err  out  1  sticky: two or more gates asserted.

## Operation
- Bus: one-hot gate select of {addr1+addr2, PC, ALU, MDR}; zero gates -> bus = 0; multiple gates -> bus = 0 and bus_err set.
- ADDR1MUX: 0 PC, 1 SR1. ADDR2MUX: 0 zero, 1 sext(IR[5:0]), 2 sext(IR[8:0]), 3 sext(IR[10:0]); all sign-extended to WIDTH.
- SR2MUX: 0 SR2 (IR[2:0]), 1 sext(IR[4:0]). SR1MUX: 0 IR[11:9], 1 IR[8:6], 2 R6, 3 R6. DRMUX: 0 IR[11:9], 1 R7, 2 R6, 3 R6.
- PCMUX: 0 PC+1, 1 bus, 2 addr1+addr2, 3 PC (hold). All adds modulo 2^WIDTH.
- ALUK: 0 ADD, 1 AND, 2 NOT A, 3 PASS A.
- CC on LD_CC from bus: N = bus[WIDTH-1], Z = (bus==0), P = otherwise. Exactly one of N/Z/P set.
- BEN on LD_BEN: (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using CC value at that edge.
- MDR FSM, states IDLE, WAIT:
  - IDLE, LD_MDR, MIO_EN=0: MDR <= bus; stay IDLE.
  - IDLE, LD_MDR, MIO_EN=1, mem_ready=1: MDR <= MDR_in; stay IDLE.
  - IDLE, LD_MDR, MIO_EN=1, mem_ready=0: -> WAIT; MDR holds.
  - WAIT, mem_ready=1: MDR <= MDR_in; -> IDLE. LD_MDR/MIO_EN ignored in WAIT.
  - WAIT, mem_ready=0: stay.
- mdr_wait = (state==WAIT), combinational from state.
- bus_err: set on any edge with >1 gate; cleared only by Reset.

## Timing
- Reset values: PC = PC_RESET, IR/MAR/MDR/R0-R7 = 0, CC = Z (3'b010), BEN = 0, state IDLE, mdr_wait = 0, bus_err = 0.
- All loads take effect at the edge where enable is high; outputs visible next cycle. Register file reads combinational, write on LD_REG edge; read-during-write returns old value.
- Memory read latency into MDR: 1 cycle if mem_ready with request, else 1 cycle after first mem_ready.
- Reset asserted in WAIT: IDLE and MDR = 0 at that edge; pending read dropped.
- LD_PC with PCMUX=0 and GatePC same cycle: bus carries old PC.

## Structure
- Package lc3_dp_pkg: ALUK, PCMUX, ADDR2MUX, DRMUX, SR1MUX enums; CC_RESET constant; MDR FSM state typedef.
- Sub-module lc3_regfile #(WIDTH): 8 x WIDTH, two async read ports, one sync write, sync reset to 0.

## Test plan
- Reset, PC_RESET='h3000: PC_out='h3000, CC=Z, BEN=0, mdr_wait=0; GatePC+LD_MAR -> MAR_out='h3000; LD_PC,PCMUX=0 -> PC_out='h3001.
- WIDTH=16, R1='h7FFF, ADD imm 1 into R2, LD_CC: R2='h8000, CC=N; IR[11]=1 LD_BEN -> BEN=1.
- LD_MDR,MIO_EN=1, mem_ready low 3 cycles then MDR_in='hBEEF: mdr_wait high 3 cycles, MDR_out='hBEEF after, LD_MDR during WAIT ignored.
- Reset during WAIT: MDR_out=0, mdr_wait=0 next cycle; later mem_ready has no effect.
- GateALU and GatePC together: bus=0, bus_err=1 and stays 1 after gates cleared until Reset.
- WIDTH=32, PC='hFFFFFFFF, PCMUX=0 LD_PC: PC=0; ADDR2MUX=3, IR[10:0]='h400: offset sext = 'hFFFFFC00.
